// File: rtl/frag_buffer_arbiter.sv
// -----------------------------------------------------------------------------
// frag_buffer_arbiter
//
// Shares the TX data-fragmentation write buffer between N_REQ TLP sources
// (e.g. posted, non-posted and completion streams). When the buffer is empty,
// one pending requester is picked round-robin. Its whole multi-beat TLP is then
// streamed into the buffer, one beat per cycle. The grant is held until the
// last beat, and then the arbiter re-arbitrates.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   req_i          per-requester TLP pending, held until its last beat is granted
//   len_i          per-requester TLP length in beats, slice k = [k*LEN_WIDTH +: LEN_WIDTH]
//   data_i         per-requester current beat data
//   loc_i          per-requester current beat location count
//   gnt_o          one-hot: the beat of requester k is written this cycle
//   busy_o         a TLP transfer is in progress
//   buf_wr_en      buffer write enable
//   buf_data_in    buffer write data
//   buf_no_loc_wr  locations written this cycle
//   buf_empty      buffer empty flag, only looked at between TLPs
// -----------------------------------------------------------------------------
module frag_buffer_arbiter #(
  parameter int N_REQ           = 3,
  parameter int WR_DATA_WIDTH   = 256,
  parameter int NO_LOC_WR_WIDTH = 3,
  parameter int LEN_WIDTH       = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_REQ-1:0]                   req_i,
  input  logic [N_REQ*LEN_WIDTH-1:0]         len_i,
  input  logic [N_REQ*WR_DATA_WIDTH-1:0]     data_i,
  input  logic [N_REQ*NO_LOC_WR_WIDTH-1:0]   loc_i,
  output logic [N_REQ-1:0]                   gnt_o,
  output logic                               busy_o,
  output logic                               buf_wr_en,
  output logic [WR_DATA_WIDTH-1:0]           buf_data_in,
  output logic [NO_LOC_WR_WIDTH-1:0]         buf_no_loc_wr,
  input  logic                               buf_empty
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t               state, state_n;
  logic [PTR_W-1:0]     rr_ptr, rr_ptr_n;
  logic [PTR_W-1:0]     sel, sel_n;
  logic [LEN_WIDTH-1:0] beat_cnt, beat_cnt_n;

  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;
  logic [PTR_W-1:0]     scan_idx;
  logic [LEN_WIDTH-1:0] win_len;

  logic [WR_DATA_WIDTH-1:0]   sel_data;
  logic [NO_LOC_WR_WIDTH-1:0] sel_loc;

  // (base + off) mod N_REQ, for off in 0..N_REQ-1.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return PTR_W'(s);
  endfunction

  // Round-robin search. The scan starts at rr_ptr, and the first pending
  // requester found wins.
  // NOTE: every always_comb output gets a default before any branch. A path
  // that leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = wrap_add(rr_ptr, i);
      if (!win_found && req_i[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Get the winner's length. A length of 0 is treated as a 1-beat TLP.
  always_comb begin
    win_len = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_idx == PTR_W'(k)) win_len = len_i[k*LEN_WIDTH +: LEN_WIDTH];
    end
    if (win_len == '0) win_len = LEN_WIDTH'(1);
  end

  // Beat data mux. It is steered only by the registered sel, so req_i never
  // reaches the buffer port combinationally.
  always_comb begin
    sel_data = '0;
    sel_loc  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (sel == PTR_W'(k)) begin
        sel_data = data_i[k*WR_DATA_WIDTH +: WR_DATA_WIDTH];
        sel_loc  = loc_i[k*NO_LOC_WR_WIDTH +: NO_LOC_WR_WIDTH];
      end
    end
  end

  // Next-state logic. buf_empty, req_i and len_i are only looked at in IDLE.
  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    sel_n      = sel;
    beat_cnt_n = beat_cnt;
    unique case (state)
      IDLE: begin
        if (buf_empty && win_found) begin
          sel_n      = win_idx;
          beat_cnt_n = win_len;
          state_n    = XFER;
        end
      end
      XFER: begin
        beat_cnt_n = beat_cnt - 1'b1;
        if (beat_cnt <= LEN_WIDTH'(1)) begin
          rr_ptr_n = (sel == PTR_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The outputs depend only on the state. Once a reset edge has forced IDLE,
  // writes and grants stop at once.
  always_comb begin
    gnt_o         = '0;
    busy_o        = 1'b0;
    buf_wr_en     = 1'b0;
    buf_data_in   = '0;
    buf_no_loc_wr = '0;
    if (state == XFER) begin
      gnt_o[sel]    = 1'b1;
      busy_o        = 1'b1;
      buf_wr_en     = 1'b1;
      buf_data_in   = sel_data;
      buf_no_loc_wr = sel_loc;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments. All
  // registers then sample the pre-edge values, whatever order the statements
  // are written in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      sel      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      sel      <= sel_n;
      beat_cnt <= beat_cnt_n;
    end
  end

endmodule

// File: tb/tb_frag_buffer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_frag_buffer_arbiter
//
// Directed scenarios for frag_buffer_arbiter, followed by a randomized run.
// The randomized run is checked against a transaction-level model. The model
// keeps a schedule queue of future grant owners. When the queue is empty, the
// model runs a round-robin pick and pushes L entries for a length-L TLP. While
// the queue holds entries, it pops one entry per cycle.
// -----------------------------------------------------------------------------
module tb_frag_buffer_arbiter;

  localparam int N    = 3;
  localparam int DW   = 256;
  localparam int LW   = 3;
  localparam int LENW = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_i = '0;
  logic [N*LENW-1:0] len_i = '0;
  logic [N*DW-1:0]   data_i = '0;
  logic [N*LW-1:0]   loc_i = '0;
  logic              buf_empty = 1'b1;
  logic [N-1:0]      gnt_o;
  logic              busy_o;
  logic              buf_wr_en;
  logic [DW-1:0]     buf_data_in;
  logic [LW-1:0]     buf_no_loc_wr;

  int n_cmp = 0;
  int n_bad = 0;

  frag_buffer_arbiter #(
    .N_REQ(N), .WR_DATA_WIDTH(DW), .NO_LOC_WR_WIDTH(LW), .LEN_WIDTH(LENW)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .len_i(len_i), .data_i(data_i),
    .loc_i(loc_i), .gnt_o(gnt_o), .busy_o(busy_o), .buf_wr_en(buf_wr_en),
    .buf_data_in(buf_data_in), .buf_no_loc_wr(buf_no_loc_wr),
    .buf_empty(buf_empty)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int            m_sched[$];
  int            m_ptr = 0;
  int            m_own, m_len, m_k;
  logic [N-1:0]  exp_gnt;
  logic          exp_wr, exp_busy;
  logic [DW-1:0] exp_data;
  logic [LW-1:0] exp_loc;

  initial begin
    forever begin
      @(negedge clk);
      exp_gnt = '0; exp_wr = 1'b0; exp_busy = 1'b0; exp_data = '0; exp_loc = '0;
      if (m_sched.size() > 0) begin
        m_own          = m_sched.pop_front();
        exp_gnt[m_own] = 1'b1;
        exp_wr         = 1'b1;
        exp_busy       = 1'b1;
        exp_data       = data_i[m_own*DW +: DW];
        exp_loc        = loc_i[m_own*LW +: LW];
        if (m_sched.size() == 0) m_ptr = (m_own + 1) % N;
      end else if (buf_empty && (req_i != '0) && !rst) begin
        m_own = -1;
        for (int i = 0; i < N; i++) begin
          m_k = (m_ptr + i) % N;
          if (m_own < 0 && req_i[m_k]) m_own = m_k;
        end
        m_len = int'(len_i[m_own*LENW +: LENW]);
        if (m_len == 0) m_len = 1;
        for (int b = 0; b < m_len; b++) m_sched.push_back(m_own);
      end
      if (rst) begin
        m_sched.delete();
        m_ptr = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic set_len(input int k, input int v);
    len_i[k*LENW +: LENW] = LENW'(v);
  endtask

  task automatic rand_data();
    for (int k = 0; k < N; k++) begin
      for (int w = 0; w < DW / 32; w++) data_i[k*DW + w*32 +: 32] = $urandom;
      loc_i[k*LW +: LW] = LW'($urandom_range(0, 7));
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; req_i = '0; buf_empty = 1'b1;
    step(); step();
    sample();
    n_cmp++;
    if ({busy_o, buf_wr_en, gnt_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got busy=%b wr=%b gnt=%b want all 0", busy_o, buf_wr_en, gnt_o);
    end
    n_cmp++;
    if (buf_data_in !== '0 || buf_no_loc_wr !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got data=%h loc=%h want 0", buf_data_in, buf_no_loc_wr);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic         on;
    logic [N-1:0] want;
    req_i = 3'b001; set_len(0, 4); buf_empty = 1'b1; rand_data();
    for (int c = 0; c < 7; c++) begin
      sample();
      on   = (c >= 1 && c <= 4);
      want = on ? 3'b001 : 3'b000;
      n_cmp++;
      if (gnt_o !== want || buf_wr_en !== on || busy_o !== on) begin
        n_bad++;
        $display("FAIL single_c%0d: got gnt=%b wr=%b busy=%b want gnt=%b wr=%b", c, gnt_o, buf_wr_en, busy_o, want, on);
      end
      if (on) begin
        n_cmp++;
        if (buf_data_in !== data_i[DW-1:0] || buf_no_loc_wr !== loc_i[LW-1:0]) begin
          n_bad++;
          $display("FAIL single_data_c%0d: got %h/%h want %h/%h", c, buf_data_in, buf_no_loc_wr, data_i[DW-1:0], loc_i[LW-1:0]);
        end
      end
      step();
      rand_data();
      if (c == 4) req_i = '0;
    end
    // rr_ptr must now be 1, so requester 1 beats requester 0.
    req_i = 3'b011; set_len(0, 1); set_len(1, 1);
    sample(); step();
    sample();
    n_cmp++;
    if (gnt_o !== 3'b010) begin
      n_bad++;
      $display("FAIL single_ptr: got gnt=%b want 010", gnt_o);
    end
    step();
    req_i = '0;
    sample(); step();
  endtask

  task automatic test_round_robin();
    int           own [12] = '{-1, 0, 0, -1, 1, 1, -1, 2, 2, -1, 0, 0};
    logic [N-1:0] want;
    rst = 1'b1; step(); rst = 1'b0;
    req_i = 3'b111; set_len(0, 2); set_len(1, 2); set_len(2, 2);
    for (int c = 0; c < 12; c++) begin
      sample();
      want = '0;
      if (own[c] >= 0) want[own[c]] = 1'b1;
      n_cmp++;
      if (gnt_o !== want || buf_wr_en !== (own[c] >= 0)) begin
        n_bad++;
        $display("FAIL rr_c%0d: got gnt=%b wr=%b want gnt=%b", c, gnt_o, buf_wr_en, want);
      end
      step();
    end
    req_i = '0;
    sample(); step();
  endtask

  task automatic test_empty_gating();
    logic on;
    req_i = 3'b010; set_len(1, 4); buf_empty = 1'b0;
    for (int c = 0; c < 17; c++) begin
      if (c == 10) buf_empty = 1'b1;
      if (c == 12) buf_empty = 1'b0;
      if (c == 15) req_i = '0;
      sample();
      on = (c >= 11 && c <= 14);
      n_cmp++;
      if (buf_wr_en !== on || gnt_o !== (on ? 3'b010 : 3'b000)) begin
        n_bad++;
        $display("FAIL empty_c%0d: got wr=%b gnt=%b want wr=%b", c, buf_wr_en, gnt_o, on);
      end
      step();
    end
    buf_empty = 1'b1;
  endtask

  task automatic test_len_zero();
    logic on;
    req_i = 3'b100; set_len(2, 0);
    for (int c = 0; c < 4; c++) begin
      if (c == 2) req_i = '0;
      sample();
      on = (c == 1);
      n_cmp++;
      if (gnt_o !== (on ? 3'b100 : 3'b000) || buf_wr_en !== on) begin
        n_bad++;
        $display("FAIL len0_c%0d: got gnt=%b wr=%b want wr=%b", c, gnt_o, buf_wr_en, on);
      end
      step();
    end
  endtask

  task automatic test_len_change();
    int           writes = 0;
    logic         on;
    req_i = 3'b010; set_len(1, 5);
    for (int c = 0; c < 9; c++) begin
      if (c == 1) set_len(1, 2);
      if (c == 6) req_i = '0;
      sample();
      on = (c >= 1 && c <= 5);
      if (buf_wr_en === 1'b1) writes++;
      n_cmp++;
      if (gnt_o !== (on ? 3'b010 : 3'b000)) begin
        n_bad++;
        $display("FAIL lenchg_c%0d: got gnt=%b want wr=%b", c, gnt_o, on);
      end
      step();
    end
    n_cmp++;
    if (writes != 5) begin
      n_bad++;
      $display("FAIL lenchg_count: got %0d beats want 5", writes);
    end
  endtask

  task automatic test_reset_mid();
    // rr_ptr is 2 on entry. The aborted TLP must leave it at 0, not advance it.
    req_i = 3'b010; set_len(1, 8);
    for (int c = 0; c < 7; c++) begin
      if (c == 3) rst = 1'b1;
      if (c == 4) begin
        rst = 1'b0; req_i = 3'b111;
        set_len(0, 1); set_len(1, 1); set_len(2, 1);
      end
      if (c == 6) req_i = '0;
      sample();
      if (c == 3) begin
        n_cmp++;
        if (gnt_o !== 3'b010) begin
          n_bad++;
          $display("FAIL rstmid_beat3: got gnt=%b want 010", gnt_o);
        end
      end
      if (c == 4) begin
        n_cmp++;
        if ({busy_o, buf_wr_en, gnt_o} !== '0 || buf_data_in !== '0 || buf_no_loc_wr !== '0) begin
          n_bad++;
          $display("FAIL rstmid_abort: got busy=%b wr=%b gnt=%b loc=%h want all 0", busy_o, buf_wr_en, gnt_o, buf_no_loc_wr);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if (gnt_o !== 3'b001) begin
          n_bad++;
          $display("FAIL rstmid_winner: got gnt=%b want 001", gnt_o);
        end
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 79) == 0);
      req_i     = N'($urandom_range(0, (1 << N) - 1));
      buf_empty = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) set_len(k, $urandom_range(0, 5));
      rand_data();
      sample();
      n_cmp++;
      if (gnt_o !== exp_gnt || buf_wr_en !== exp_wr || busy_o !== exp_busy ||
          buf_data_in !== exp_data || buf_no_loc_wr !== exp_loc) begin
        n_bad++;
        $display("FAIL rand_c%0d: got gnt=%b wr=%b busy=%b loc=%h data=%h want gnt=%b wr=%b busy=%b loc=%h data=%h",
                 c, gnt_o, buf_wr_en, busy_o, buf_no_loc_wr, buf_data_in,
                 exp_gnt, exp_wr, exp_busy, exp_loc, exp_data);
      end
      n_cmp++;
      if (!$onehot0(gnt_o) || ((gnt_o != '0) !== buf_wr_en)) begin
        n_bad++;
        $display("FAIL rand_onehot_c%0d: got gnt=%b wr=%b want one-hot gnt matching wr", c, gnt_o, buf_wr_en);
      end
      step();
    end
    rst = 1'b0; req_i = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_empty_gating();
    test_len_zero();
    test_len_change();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frag_buffer_arbiter.md
Name: frag_buffer_arbiter

Overview:
- Shares the data-fragmentation write buffer between N TLP sources on the TX path, e.g. posted, non-posted and completion streams from the AXI slave side.
- Picks one requester round-robin and streams its whole multi-beat TLP into the buffer through the arbiter-side buffer port (wr_en, data_in, no_loc_wr; empty returned).
- Holds the grant until the last beat, then re-arbitrates. A new TLP starts only when the buffer reports empty.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- WR_DATA_WIDTH, 256, width of one buffer write word.
- NO_LOC_WR_WIDTH, 3, width of the per-write location count.
- LEN_WIDTH, 10, width of the TLP length in write beats.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_i  in  N_REQ  per-requester TLP pending; held high until the last beat is granted.
- len_i  in  N_REQ*LEN_WIDTH  per-requester TLP length in beats; slice k = [k*LEN_WIDTH +: LEN_WIDTH].
- data_i  in  N_REQ*WR_DATA_WIDTH  per-requester current beat data.
- loc_i  in  N_REQ*NO_LOC_WR_WIDTH  per-requester current beat location count.
- gnt_o  out  N_REQ  one-hot; bit k high = beat of requester k written this cycle, requester advances to next beat.
- busy_o  out  1  high while a TLP transfer is in progress.
- buf_wr_en  out  1  buffer write enable.
- buf_data_in  out  WR_DATA_WIDTH  buffer write data.
- buf_no_loc_wr  out  NO_LOC_WR_WIDTH  locations written this cycle.
- buf_empty  in  1  buffer empty flag.

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - state=IDLE, rr_ptr=0, sel=0, beat_cnt=0.
  - Outputs: gnt_o=0, busy_o=0, buf_wr_en=0, buf_data_in=0, buf_no_loc_wr=0.
  - Reset mid-transfer aborts the TLP immediately; no further writes occur.
- FSM states: IDLE, XFER.
- IDLE:
  - If buf_empty=1 and |req_i, pick the winner = first k with req_i[k]=1, scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - Latch sel=k and beat_cnt=len_i[k] (len 0 treated as 1), then go to XFER.
  - Else stay in IDLE.
  - No writes and no grants in IDLE.
- XFER:
  - Every cycle: buf_wr_en=1, buf_data_in=data_i[sel], buf_no_loc_wr=loc_i[sel], gnt_o=one-hot(sel), busy_o=1.
  - beat_cnt decrements each cycle.
  - When beat_cnt==1: this is the last beat; set rr_ptr=(sel+1) mod N_REQ and go to IDLE.
  - The data mux is driven from the registered sel only; there is no combinational path from req_i to buf_* outputs.
- Latency:
  - Request seen in IDLE with buf_empty=1 -> first write in the next cycle.
  - A len-L TLP occupies exactly L consecutive write cycles.
  - Minimum gap between TLPs is 1 IDLE cycle.
- Boundary rules:
  - buf_empty is sampled only in IDLE. Deassertion during XFER is ignored, since the buffer is sized for one max TLP.
  - req_i and len_i changes during XFER are ignored. The length is locked at grant.
  - A requester dropping req mid-TLP is a protocol violation. The arbiter still completes beat_cnt writes.
  - Simultaneous requests are resolved only by rr_ptr; no fixed priority.
  - A requester whose req rises in the same cycle a TLP ends is eligible at the next IDLE evaluation.
  - rr_ptr wraps from N_REQ-1 to 0.
  - rr_ptr advances only on TLP completion, never on idle cycles.
- gnt_o is one-hot or zero at all times. gnt_o != 0 if and only if buf_wr_en=1.

Test Plan:
- Reset, then req_i=3'b001, len_i[0]=4, buf_empty=1 -> one IDLE cycle, then buf_wr_en=1 and gnt_o=3'b001 for exactly 4 cycles; data_in tracks data_i[0]; then IDLE with rr_ptr=1.
- req_i=3'b111 held, all len=2, buf_empty=1 always -> grant order 0,1,2,0 with 2 write cycles each and 1 IDLE cycle between TLPs.
- buf_empty=0 while req_i=3'b010 -> no writes; buf_empty rises at cycle 10 -> first write at cycle 11; buf_empty dropping at cycle 12 does not stop the remaining beats.
- len_i[2]=0, req_i=3'b100 -> exactly 1 write beat, gnt_o=3'b100 for 1 cycle.
- rst asserted on the 3rd beat of a len=8 TLP -> next cycle all outputs 0, state IDLE, rr_ptr=0; after release, requester 0 wins first.
- len_i[1] changes from 5 to 2 in the first XFER cycle -> 5 beats still written.
